// File: rtl/reg_access_arb_pkg.sv
// Shared constants for the register-access arbiter: FSM encoding and timeout sizing.
package reg_access_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam int TIMEOUT_CNT_WIDTH      = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/reg_access_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic found;
    int   cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Shares one reg_wr_*/reg_rd_* port among NUM_REQ requesters, one access in flight.
// Define REG_ACCESS_ARB_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES with rsp_err.
module reg_access_arbiter
    import reg_access_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_strb,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [ADDR_WIDTH-1:0]            reg_wr_addr,
    output logic [DATA_WIDTH-1:0]            reg_wr_data,
    output logic [STRB_WIDTH-1:0]            reg_wr_strb,
    output logic                             reg_wr_en,
    input  logic                             reg_wr_wait,
    input  logic                             reg_wr_ack,
    output logic [ADDR_WIDTH-1:0]            reg_rd_addr,
    output logic                             reg_rd_en,
    input  logic [DATA_WIDTH-1:0]            reg_rd_data,
    input  logic                             reg_rd_wait,
    input  logic                             reg_rd_ack
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("reg_access_arbiter: NUM_REQ must be 2..8");
    end
    if (STRB_WIDTH != DATA_WIDTH / 8) begin : g_bad_strb
        $error("reg_access_arbiter: STRB_WIDTH must be DATA_WIDTH/8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2**TIMEOUT_CNT_WIDTH) begin : g_bad_tmo
        $error("reg_access_arbiter: TIMEOUT_CYCLES out of counter range");
    end

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
    } acc_t;

    // Packed 2-D views line up with the flat ports: element i is slice i.
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_arr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_arr;
    logic [NUM_REQ-1:0][STRB_WIDTH-1:0] strb_arr;

    assign addr_arr  = req_addr;
    assign wdata_arr = req_wdata;
    assign strb_arr  = req_strb;

    arb_state_t            state_q, state_d;
    acc_t                  acc_q;
    logic [IDX_W-1:0]      ptr_q, gnt_idx_q, arb_idx;
    logic [NUM_REQ-1:0]    gnt_oh_q, arb_gnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  accept, done, timeout;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign accept = (state_q == ST_IDLE) && (|req_valid) && !rst;
    // Only the ack matching the latched direction, and only while not stalled, completes.
    assign done   = acc_q.we ? (reg_wr_ack & ~reg_wr_wait) : (reg_rd_ack & ~reg_rd_wait);

`ifdef REG_ACCESS_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_CNT_WIDTH-1:0] TMO_LAST = TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_CNT_WIDTH-1:0] tmo_cnt_q;
    logic                         err_q;

    // A qualified ack on the limit cycle wins over the abort.
    assign timeout = (state_q == ST_ACCESS) && !done && (tmo_cnt_q == TMO_LAST);
    assign rsp_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept)
                tmo_cnt_q <= '0;
            else if (state_q == ST_ACCESS)
                tmo_cnt_q <= tmo_cnt_q + TIMEOUT_CNT_WIDTH'(1);
            if (state_q == ST_ACCESS && (done || timeout))
                err_q <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_ready = arb_gnt;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                reg_wr_en = acc_q.we;
                reg_rd_en = !acc_q.we;
                if (done || timeout) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = gnt_oh_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            gnt_oh_q  <= '0;
            acc_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                gnt_idx_q <= arb_idx;
                gnt_oh_q  <= arb_gnt;
                acc_q     <= '{we:    req_we[arb_idx],
                               addr:  addr_arr[arb_idx],
                               wdata: wdata_arr[arb_idx],
                               strb:  strb_arr[arb_idx]};
            end
            if (state_q == ST_ACCESS && (done || timeout))
                rdata_q <= (acc_q.we || !done) ? '0 : reg_rd_data;
            if (state_q == ST_RESP)
                ptr_q <= (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
        end
    end

    assign reg_wr_addr = acc_q.addr;
    assign reg_wr_data = acc_q.wdata;
    assign reg_wr_strb = acc_q.strb;
    assign reg_rd_addr = acc_q.addr;
    assign rsp_rdata   = rdata_q;

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Shares one register-access port (reg_wr_*/reg_rd_* strobe interface, as produced by the AXI-Lite register bridge) between NUM_REQ internal requesters, e.g. a host AXI-Lite bridge and on-chip LED/ICAP sequencers.
- Sits between the requesters and the register file.
- Round-robin grant; one outstanding access at a time; per-requester response.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 16, register address width.
- DATA_WIDTH, 32, register data width.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.
- TIMEOUT_CYCLES, 255, access-abort limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester access request.
- req_we  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_strb  in  NUM_REQ*STRB_WIDTH  packed write strobes.
- req_ready  out  NUM_REQ  one-hot acceptance pulse.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid.
- rsp_err  out  1  timeout flag; valid with rsp_valid.
- reg_wr_addr  out  ADDR_WIDTH  write address.
- reg_wr_data  out  DATA_WIDTH  write data.
- reg_wr_strb  out  STRB_WIDTH  write strobes.
- reg_wr_en  out  1  write strobe.
- reg_wr_wait  in  1  write stall.
- reg_wr_ack  in  1  write done.
- reg_rd_addr  out  ADDR_WIDTH  read address.
- reg_rd_en  out  1  read strobe.
- reg_rd_data  in  DATA_WIDTH  read data.
- reg_rd_wait  in  1  read stall.
- reg_rd_ack  in  1  read done.

Behaviour:
- Clock and reset: single clock, clk. Reset is rst, synchronous, active-high.
- Reset values: all outputs 0; state IDLE; round-robin pointer 0.
- FSM IDLE:
  - If any req_valid is high, grant the first requester at or after the pointer (wrapping modulo NUM_REQ).
  - Register its we/addr/wdata/strb.
  - Pulse req_ready[gnt] for that same cycle (combinational from the registered-state decision), then go to ACCESS.
  - No requests: stay in IDLE.
- FSM ACCESS:
  - Write: reg_wr_en=1 with the latched addr/data/strb.
  - Read: reg_rd_en=1 with the latched addr.
  - The strobe is held high until the cycle where the matching ack=1 and wait=0.
  - In that cycle, capture reg_rd_data (reads) or 0 (writes) and go to RESP.
  - Ack while wait=1 is ignored.
  - The opposite-direction ack is ignored.
- FSM RESP:
  - rsp_valid[gnt]=1 for exactly one cycle, with rsp_rdata and rsp_err.
  - Pointer <= (gnt+1) mod NUM_REQ.
  - Go to IDLE.
- Latency:
  - Request accepted in cycle 0; en asserted cycles 1..k; with ack in cycle 1, rsp_valid in cycle 2.
  - Next grant no earlier than cycle 3, giving a minimum of 3 cycles per access.
- Requester rules:
  - A requester must hold req_valid and its fields stable until req_ready.
  - After req_ready, its fields may change; they are not re-sampled.
  - A requester deasserting req_valid before its grant is simply skipped.
- Fairness: with all requesters permanently requesting, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 accesses.
- Strobe exclusivity: reg_wr_en and reg_rd_en are never high together, and are never high outside ACCESS.
- Reset mid-access:
  - The next edge forces IDLE, drops en, and clears the pointer.
  - The in-flight access gets no rsp_valid.

Optional Feature:
- Macro REG_ACCESS_ARB_TIMEOUT_EN.
- When defined:
  - An 8..16-bit counter clears on entering ACCESS and increments each ACCESS cycle.
  - If it reaches TIMEOUT_CYCLES without a qualified ack, drop en and go to RESP with rsp_err=1 and rsp_rdata=0.
  - An ack arriving in the same cycle as the limit wins: normal completion, rsp_err=0.
- When undefined:
  - No counter; ACCESS waits indefinitely.
  - rsp_err is tied to 0.

Decomposition:
- Package reg_access_arb_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2;
  - the TIMEOUT_CNT_WIDTH constant;
  - the default TIMEOUT_CYCLES.
- Sub-module rr_arbiter:
  - Parameterised NUM_REQ.
  - Inputs: request vector and pointer.
  - Output: one-hot grant plus binary index.
  - Purely combinational; reused by other shared-resource blocks.

Test Plan:
- Single read: req0 read addr 0x0000, reg_rd_ack tied 1, reg_rd_data=0x000000A5 -> req_ready[0] in cycle 0, reg_rd_en high in cycle 1 only, rsp_valid[0] in cycle 2 with rsp_rdata=0x000000A5, rsp_err=0.
- Write with stall: req1 write addr 0x0000, data 0x3C, strb 0x1; reg_wr_wait=1 for 3 cycles then ack -> reg_wr_en held 4 cycles with stable addr/data/strb; rsp_valid[1] one cycle after the qualified ack.
- Contention: req0 and req1 both valid continuously for 6 accesses -> grant order 0,1,0,1,0,1; no back-to-back repeat.
- Reset mid-access: assert rst during reg_rd_en with wait=1 -> reg_rd_en=0 at the next edge; no rsp_valid; the next request after reset is granted from pointer 0.
- Timeout (macro defined, TIMEOUT_CYCLES=8): read with ack never asserted -> reg_rd_en high for 8 cycles, then rsp_valid with rsp_err=1 and rsp_rdata=0. Macro undefined: en stays high past 8 cycles and rsp_err stays 0.
- Direction check: write pending while reg_rd_ack pulses -> ignored; completion only on reg_wr_ack.
